win_sequencer: RTL and testbench
================================

WIN_SEQUENCER -- requirements
Module: win_sequencer

Interface
REQ-001 SHALL have parameter NUM_RECTS, default 19, number of win-screen rectangles to reveal (legal range 1..51).
REQ-002 SHALL have parameter FRAMES_PER_STEP, default 4, frame_start pulses per revealed rectangle (minimum 1).
REQ-003 SHALL have parameter BLINK_FRAMES, default 30, frame_start pulses per blink half-period (minimum 1).
REQ-004 SHALL have parameter HOLD_FRAMES, default 300, frame_start pulses in HOLD before auto-restart (minimum 1).
REQ-005 SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port frame_start, input, 1 bit, one-cycle pulse at the start of each video frame.
REQ-009 SHALL have port goal_reached, input, 1 bit, level or pulse from the maze logic when the player reaches the exit.
REQ-010 SHALL have port restart_btn, input, 1 bit, synchronized, debounced button level.
REQ-011 SHALL have port reveal_count, output, 6 bits, number of win rectangles (indices 0..reveal_count-1) the pixel checker draws.
REQ-012 SHALL have port win_active, output, 1 bit, high in REVEAL and HOLD.
REQ-013 SHALL have port win_visible, output, 1 bit, gate for drawing the win rectangles.
REQ-014 SHALL have port game_restart, output, 1 bit, one-cycle pulse that resets the maze/player logic.
REQ-015 SHALL have port wins_total, output, 8 bits, count of completed wins.

Function
REQ-016 SHALL implement the states PLAY, REVEAL, HOLD and RESTART, all registered.
REQ-017 In PLAY, when goal_reached=1, the block SHALL enter REVEAL next cycle, with reveal_count=0 and frame_cnt=0.
REQ-018 On PLAY->REVEAL, wins_total SHALL increment, saturating at 255.
REQ-019 In REVEAL, each frame_start SHALL increment frame_cnt.
REQ-020 In REVEAL, a frame_start with frame_cnt==FRAMES_PER_STEP-1 SHALL clear frame_cnt and increment reveal_count next cycle.
REQ-021 In REVEAL, when the reveal_count increment makes it equal NUM_RECTS, the block SHALL enter HOLD in that same update.
REQ-022 In REVEAL, restart_btn and goal_reached SHALL be ignored.
REQ-023 On HOLD entry, hold_cnt SHALL be 0, blink_cnt SHALL be 0 and blink_on SHALL be 1; reveal_count SHALL stay at NUM_RECTS.
REQ-024 In HOLD, each frame_start SHALL increment hold_cnt and blink_cnt.
REQ-025 In HOLD, when blink_cnt==BLINK_FRAMES-1 on a frame_start, blink_cnt SHALL clear and blink_on SHALL toggle.
REQ-026 In HOLD, a frame_start with hold_cnt==HOLD_FRAMES-1 SHALL move the block to RESTART.
REQ-027 In HOLD, a rising edge of restart_btn (restart_btn=1, previous-cycle sample=0) SHALL move the block to RESTART; when coincident with frame_start, restart wins and the counters are not updated.
REQ-028 restart_btn already held high on HOLD entry SHALL NOT trigger a restart until it is released and pressed again.
REQ-029 In RESTART, game_restart SHALL be 1 for exactly one cycle, reveal_count SHALL clear to 0, and the next state SHALL be PLAY.
REQ-030 goal_reached in RESTART SHALL be ignored; goal_reached in PLAY on the cycle immediately after RESTART SHALL be honoured.
REQ-031 win_visible SHALL equal 1 in REVEAL, blink_on in HOLD, and 0 otherwise.
REQ-032 All outputs SHALL be registered or decoded only from registered state, with no combinational path from the inputs.
REQ-033 Counters SHALL be sized by $clog2 of their parameter; no counter SHALL wrap except by the explicit clears above.

Reset
REQ-034 When reset=1, state SHALL be PLAY and reveal_count=0, win_active=0, win_visible=0, game_restart=0 and wins_total=0.
REQ-035 When reset=1, all internal counters SHALL be 0, blink_on SHALL be 0 and the restart_btn history SHALL be 0.
REQ-036 Reset SHALL take priority over every other input in any state, including mid-REVEAL and mid-HOLD.

Verification (NUM_RECTS=3, FRAMES_PER_STEP=2, BLINK_FRAMES=2, HOLD_FRAMES=6)
REQ-037 Reveal: pulse goal_reached, then 6 frame_starts -> reveal_count steps 1,2,3 after frame_starts 2, 4 and 6; HOLD entered after the 6th; wins_total=1.
REQ-038 Blink/auto-restart: in HOLD, 6 frame_starts -> win_visible pattern 1,1,0,0,1,1; then game_restart pulses for one cycle; PLAY with reveal_count=0.
REQ-039 Manual restart: restart_btn 0->1 in HOLD, coincident with frame_start -> RESTART next cycle; hold_cnt not advanced; game_restart for one cycle.
REQ-040 Held button and ignored inputs: restart_btn high before HOLD entry -> no restart until it is released and re-pressed; restart_btn and goal_reached during REVEAL -> no effect.
REQ-041 Reset mid-operation and saturation: reset asserted in REVEAL with reveal_count=2 -> all outputs at reset values next cycle; 256 wins -> wins_total stays 255.

Source files
------------

// File: rtl/win_sequencer.sv
// Win-screen sequencer: on reaching the goal, reveals the win rectangles one step at a time,
// then blinks them in HOLD until a timeout or a fresh restart press pulses game_restart.
module win_sequencer #(
  parameter int NUM_RECTS       = 19,
  parameter int FRAMES_PER_STEP = 4,
  parameter int BLINK_FRAMES    = 30,
  parameter int HOLD_FRAMES     = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       goal_reached,
  input  logic       restart_btn,
  output logic [5:0] reveal_count,
  output logic       win_active,
  output logic       win_visible,
  output logic       game_restart,
  output logic [7:0] wins_total
);

  // A parameter of 1 still needs a 1-bit counter; $clog2(1) would give zero width.
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
  localparam logic [5:0]    RECT_LAST  = 6'(NUM_RECTS - 1);

  typedef enum logic [1:0] {
    S_PLAY,
    S_REVEAL,
    S_HOLD,
    S_RESTART
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [FW-1:0]   r_frame_cnt;
  logic [BW-1:0]   r_blink_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_blink_on;
  logic            r_btn_prev;
  logic [5:0]      r_reveal_count;
  logic [7:0]      r_wins;

  logic w_btn_rise;
  logic w_step_done;
  logic w_reveal_done;
  logic w_hold_done;

  assign w_btn_rise    = restart_btn & ~r_btn_prev;
  assign w_step_done   = frame_start && (r_frame_cnt == FRAME_LAST);
  assign w_reveal_done = w_step_done && (r_reveal_count == RECT_LAST);
  assign w_hold_done   = frame_start && (r_hold_cnt == HOLD_LAST);

  // NOTE: the reset here is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_PLAY;
    else       r_state <= w_state_next;
  end

  // NOTE: default first so every path assigns w_state_next and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_PLAY:    if (goal_reached) w_state_next = S_REVEAL;
      S_REVEAL:  if (w_reveal_done) w_state_next = S_HOLD;
      S_HOLD:    if (w_btn_rise || w_hold_done) w_state_next = S_RESTART;
      S_RESTART: w_state_next = S_PLAY;
      default:   w_state_next = S_PLAY;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt    <= '0;
      r_blink_cnt    <= '0;
      r_hold_cnt     <= '0;
      r_blink_on     <= 1'b0;
      r_btn_prev     <= 1'b0;
      r_reveal_count <= '0;
      r_wins         <= '0;
    end else begin
      r_btn_prev <= restart_btn;
      case (r_state)
        S_PLAY: begin
          if (goal_reached) begin
            r_reveal_count <= '0;
            r_frame_cnt    <= '0;
            if (r_wins != 8'hFF) r_wins <= r_wins + 8'd1;
          end
        end
        S_REVEAL: begin
          if (w_step_done) begin
            r_frame_cnt    <= '0;
            r_reveal_count <= r_reveal_count + 6'd1;
            if (w_reveal_done) begin
              r_hold_cnt  <= '0;
              r_blink_cnt <= '0;
              r_blink_on  <= 1'b1;
            end
          end else if (frame_start) begin
            r_frame_cnt <= r_frame_cnt + FW'(1);
          end
        end
        S_HOLD: begin
          // A restart press wins over a coincident frame: the counters stay put.
          if (frame_start && !w_btn_rise && !w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
            if (r_blink_cnt == BLINK_LAST) begin
              r_blink_cnt <= '0;
              r_blink_on  <= ~r_blink_on;
            end else begin
              r_blink_cnt <= r_blink_cnt + BW'(1);
            end
          end
        end
        S_RESTART: begin
          r_reveal_count <= '0;
          r_blink_on     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign reveal_count = r_reveal_count;
  assign win_active   = (r_state == S_REVEAL) || (r_state == S_HOLD);
  assign win_visible  = (r_state == S_REVEAL) || ((r_state == S_HOLD) && r_blink_on);
  assign game_restart = (r_state == S_RESTART);
  assign wins_total   = r_wins;

endmodule

// File: tb/tb_win_sequencer.sv
// Self-checking bench for win_sequencer: directed scenarios plus random stimulus,
// all compared against a frame-counting reference model.
module tb_win_sequencer;

  localparam int NR  = 3;
  localparam int FPS = 2;
  localparam int BF  = 2;
  localparam int HF  = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_start = 1'b0;
  logic       goal_reached = 1'b0;
  logic       restart_btn = 1'b0;
  logic [5:0] reveal_count;
  logic       win_active;
  logic       win_visible;
  logic       game_restart;
  logic [7:0] wins_total;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef enum int {M_PLAY, M_REVEAL, M_HOLD, M_RESTART} phase_e;
  phase_e m_phase  = M_PLAY;
  int     m_frames = 0;  // frame_starts seen since entering REVEAL
  int     m_hold   = 0;  // frame_starts seen since entering HOLD
  int     m_wins   = 0;
  bit     m_prev   = 1'b0;

  always #5 clk = ~clk;

  win_sequencer #(
    .NUM_RECTS(NR), .FRAMES_PER_STEP(FPS), .BLINK_FRAMES(BF), .HOLD_FRAMES(HF)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .goal_reached(goal_reached),
    .restart_btn(restart_btn), .reveal_count(reveal_count), .win_active(win_active),
    .win_visible(win_visible), .game_restart(game_restart), .wins_total(wins_total)
  );

  function automatic void model_step(input bit fs, input bit gr, input bit btn, input bit rst);
    bit rise;
    if (rst) begin
      m_phase = M_PLAY; m_frames = 0; m_hold = 0; m_wins = 0; m_prev = 1'b0;
      return;
    end
    rise   = btn && !m_prev;
    m_prev = btn;
    case (m_phase)
      M_PLAY: if (gr) begin
        m_phase  = M_REVEAL;
        m_frames = 0;
        m_wins   = (m_wins < 255) ? m_wins + 1 : 255;
      end
      M_REVEAL: if (fs) begin
        m_frames++;
        if (m_frames == NR * FPS) begin m_phase = M_HOLD; m_hold = 0; end
      end
      M_HOLD: begin
        if (rise) m_phase = M_RESTART;
        else if (fs) begin
          m_hold++;
          if (m_hold == HF) m_phase = M_RESTART;
        end
      end
      default: m_phase = M_PLAY;
    endcase
  endfunction

  // Expected {reveal_count, win_active, win_visible, game_restart, wins_total}.
  function automatic logic [16:0] exp_vec();
    logic [5:0] rc;
    logic act, vis, grs;
    rc = 6'd0; act = 1'b0; vis = 1'b0; grs = 1'b0;
    case (m_phase)
      M_REVEAL:  begin rc = 6'(m_frames / FPS); act = 1'b1; vis = 1'b1; end
      M_HOLD:    begin rc = 6'(NR); act = 1'b1; vis = (((m_hold / BF) % 2) == 0); end
      M_RESTART: grs = 1'b1;
      default: ;
    endcase
    return {rc, act, vis, grs, 8'(m_wins)};
  endfunction

  // reveal_count during the single RESTART cycle is not pinned down, so it is masked there.
  function automatic logic [16:0] mask_vec();
    return (m_phase == M_RESTART) ? {6'h00, 11'h7FF} : 17'h1FFFF;
  endfunction

  function automatic logic [16:0] obs_vec();
    return {reveal_count, win_active, win_visible, game_restart, wins_total};
  endfunction

  task automatic drive(input bit fs, input bit gr, input bit btn, input bit rst);
    frame_start = fs; goal_reached = gr; restart_btn = btn; reset = rst;
    @(posedge clk);
    model_step(fs, gr, btn, rst);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (obs_vec() !== 17'h0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs_vec(), 17'h0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reveal();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
      n_fail++; $display("FAIL reveal_enter cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
    end
    for (int f = 1; f <= NR * FPS; f++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
        n_fail++; $display("FAIL reveal_step cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      n_checks++;
      if (reveal_count !== 6'(f / FPS)) begin
        n_fail++; $display("FAIL reveal_count f=%0d got=%0d want=%0d", f, reveal_count, f / FPS);
      end
    end
    n_checks++;
    if (!(win_active === 1'b1 && win_visible === 1'b1 && wins_total === 8'd1 && reveal_count === 6'd3)) begin
      n_fail++; $display("FAIL hold_entry got=%h want rc=3 act=1 vis=1 wins=1", obs_vec());
    end
  endtask

  task automatic test_blink_auto_restart();
    bit pat[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < HF; k++) begin
      n_checks++;
      if (win_visible !== pat[k] || game_restart !== 1'b0) begin
        n_fail++; $display("FAIL blink k=%0d got vis=%b gr=%b want vis=%b gr=0", k, win_visible, game_restart, pat[k]);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    n_checks++;
    if (game_restart !== 1'b1 || win_active !== 1'b0) begin
      n_fail++; $display("FAIL auto_restart got gr=%b act=%b want gr=1 act=0", game_restart, win_active);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs_vec() !== {6'd0, 1'b0, 1'b0, 1'b0, 8'd1}) begin
      n_fail++; $display("FAIL back_to_play got=%h want=%h", obs_vec(), {6'd0, 3'b000, 8'd1});
    end
  endtask

  task automatic reach_hold(input bit btn);
    drive(1'b0, 1'b1, btn, 1'b0);
    for (int f = 0; f < NR * FPS; f++) drive(1'b1, 1'b0, btn, 1'b0);
  endtask

  task automatic test_manual_restart();
    reach_hold(1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (game_restart !== 1'b1 || (obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
      n_fail++; $display("FAIL manual_restart got=%h want=%h", obs_vec(), exp_vec());
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (game_restart !== 1'b0 || reveal_count !== 6'd0 || win_active !== 1'b0) begin
      n_fail++; $display("FAIL restart_one_cycle got=%h want=%h", obs_vec(), exp_vec());
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_held_button();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    for (int f = 0; f < NR * FPS; f++) begin
      // Button released and re-pressed mid-REVEAL, goal held: both must be ignored.
      drive(1'b0, 1'b1, (f != 2), 1'b0);
      drive(1'b1, 1'b1, (f != 2), 1'b0);
      n_checks++;
      if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
        n_fail++; $display("FAIL ignore_in_reveal cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (game_restart !== 1'b0 || win_active !== 1'b1) begin
        n_fail++; $display("FAIL held_btn cyc=%0d got gr=%b act=%b want gr=0 act=1", cyc, game_restart, win_active);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (game_restart !== 1'b1 || (obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
      n_fail++; $display("FAIL repress got=%h want=%h", obs_vec(), exp_vec());
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int f = 0; f < 2 * FPS; f++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (reveal_count !== 6'd2 || win_active !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got rc=%0d act=%b want rc=2 act=1", reveal_count, win_active);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (obs_vec() !== 17'h0) begin
      n_fail++; $display("FAIL reset_mid got=%h want=%h", obs_vec(), 17'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit btn = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) btn = ~btn;
      drive(($urandom_range(1) == 1), ($urandom_range(3) == 0), btn, ($urandom_range(199) == 0));
      n_checks++;
      if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 258; w++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ((obs_vec() & mask_vec()) !== (exp_vec() & mask_vec())) begin
        n_fail++; $display("FAIL saturation w=%0d got=%h want=%h", w, obs_vec(), exp_vec());
      end
      for (int f = 0; f < NR * FPS; f++) drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_checks++;
    if (wins_total !== 8'd255) begin
      n_fail++; $display("FAIL wins_saturate got=%0d want=255", wins_total);
    end
  endtask

  initial begin
    test_reset();
    test_reveal();
    test_blink_auto_restart();
    test_manual_restart();
    test_held_button();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
